// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue: instruction fetch unit with a small prefetch queue.
// Generates sequential fetch addresses, runs a request/valid handshake with
// instruction memory and buffers up to DEPTH {instruction, pc} entries for
// the decode stage. Supports halt (no new requests) and redirect (flush and
// restart fetch at a new pc).
//
// Ports
//   clock_in, reset_in         clock, synchronous active-high reset
//   halt_in                    suppress launch of new fetch requests
//   redirect_in/_addr_in       flush queue and restart fetch at new pc
//   mem_addr_out/mem_read_out  fetch request to instruction memory
//   mem_valid_in/mem_data_in   memory response for the current request
//   ins_valid_out/ins_ready_in valid/ready stream to decode
//   ins_data_out/ins_pc_out    head instruction and its pc
//   queue_count_out            occupied queue entries
module ifu_prefetch_queue #(
   parameter int unsigned          XLEN       = 32,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [XLEN-1:0]      RESET_ADDR = '0,
   parameter int unsigned          PC_STEP    = 4
) (
   input  logic                         clock_in,
   input  logic                         reset_in,
   input  logic                         halt_in,
   input  logic                         redirect_in,
   input  logic [XLEN-1:0]              redirect_addr_in,
   output logic [XLEN-1:0]              mem_addr_out,
   output logic                         mem_read_out,
   input  logic                         mem_valid_in,
   input  logic [31:0]                  mem_data_in,
   output logic                         ins_valid_out,
   input  logic                         ins_ready_in,
   output logic [31:0]                  ins_data_out,
   output logic [XLEN-1:0]              ins_pc_out,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count_out
);

   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic              mem_read_q, mem_read_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ins_valid_q, ins_valid_d;
   logic [31:0]       ins_data_q, ins_data_d;
   logic [XLEN-1:0]   ins_pc_q, ins_pc_d;

   logic [31:0]       q_data_q [DEPTH];
   logic [XLEN-1:0]   q_pc_q   [DEPTH];

   logic              busy;
   logic              hold;
   logic              push;
   logic              pop;
   logic [CW-1:0]     occ_n;
   logic              launch_ok;

   // Next-state, queue bookkeeping and registered head computation
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      ins_valid_d = 1'b0;
      ins_data_d  = NOP;
      ins_pc_d    = '0;

      busy      = (state_q != ST_IDLE);
      hold      = busy & ~mem_valid_in;
      push      = (state_q == ST_REQ) & mem_valid_in & ~redirect_in;
      pop       = ins_valid_q & ins_ready_in & ~redirect_in;
      occ_n     = count_q + CW'(push) - CW'(pop);
      launch_ok = ~halt_in & (occ_n < CW'(DEPTH));

      if (redirect_in) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_addr_in;
         // An unfinished request must still be retired; its data is dropped
         if (hold) state_d = ST_DROP;
         else      state_d = halt_in ? ST_IDLE : ST_REQ;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = occ_n;

         if (hold)                       state_d = state_q;
         else if (state_q == ST_DROP)    state_d = halt_in ? ST_IDLE : ST_REQ;
         else                            state_d = launch_ok ? ST_REQ : ST_IDLE;
      end

      // Address stays put while a request is outstanding, else tracks fetch pc
      mem_addr_d = hold ? mem_addr_q : fetch_pc_d;
      mem_read_d = (state_d != ST_IDLE);

      // Head after this edge; a word pushed into an empty slot bypasses storage
      if (count_d != '0) begin
         ins_valid_d = 1'b1;
         if (push && (rd_ptr_d == wr_ptr_q)) begin
            ins_data_d = mem_data_in;
            ins_pc_d   = mem_addr_q;
         end else begin
            ins_data_d = q_data_q[rd_ptr_d];
            ins_pc_d   = q_pc_q[rd_ptr_d];
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_ADDR;
         mem_addr_q  <= RESET_ADDR;
         mem_read_q  <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         ins_valid_q <= 1'b0;
         ins_data_q  <= NOP;
         ins_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         ins_valid_q <= ins_valid_d;
         ins_data_q  <= ins_data_d;
         ins_pc_q    <= ins_pc_d;
      end
   end

   // Queue storage; contents are qualified by count, so no reset needed
   always_ff @(posedge clock_in) begin
      if (!reset_in && push) begin
         q_data_q[wr_ptr_q] <= mem_data_in;
         q_pc_q[wr_ptr_q]   <= mem_addr_q;
      end
   end

   assign mem_addr_out    = mem_addr_q;
   assign mem_read_out    = mem_read_q;
   assign ins_valid_out   = ins_valid_q;
   assign ins_data_out    = ins_data_q;
   assign ins_pc_out      = ins_pc_q;
   assign queue_count_out = count_q;

endmodule

// File: doc/ifu_prefetch_queue.md
# ifu_prefetch_queue

Parametrised instruction fetch unit with a prefetch queue. It replaces the fixed-increment PC/IR pair: it generates sequential fetch addresses, runs a request/valid handshake with instruction memory, and buffers up to DEPTH fetched words with their PCs. It presents a valid/ready stream to the decode stage and supports halt and redirect (flush plus new PC), sitting between instruction memory and decode in the core top.

## Interface
- XLEN, 32, address/PC width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_ADDR, 32'h00000000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment.

- clock_in  in  1  core clock; all state updates on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- halt_in  in  1  suppresses launch of new fetch requests.
- redirect_in  in  1  flush the queue and restart fetch at redirect_addr_in.
- redirect_addr_in  in  XLEN  new fetch PC, sampled when redirect_in=1.
- mem_addr_out  out  XLEN  fetch address.
- mem_read_out  out  1  fetch request outstanding.
- mem_valid_in  in  1  memory returns mem_data_in for the current request.
- mem_data_in  in  32  instruction word.
- ins_valid_out  out  1  queue head valid.
- ins_ready_in  in  1  decode accepts the head.
- ins_data_out  out  32  head instruction.
- ins_pc_out  out  XLEN  head PC.
- queue_count_out  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- FSM states: IDLE (no request), REQ (request outstanding), DROP (request outstanding whose data will be discarded). mem_read_out=1 in REQ and DROP. mem_addr_out is held stable until mem_valid_in.
- Completion: mem_valid_in=1 while mem_read_out=1. A response in the same cycle the request is raised is legal (combinational memory). mem_valid_in is ignored in IDLE.
- push: completion in REQ without redirect_in. The entry {mem_data_in, mem_addr_out} is written at wr_ptr, and fetch_pc advances by PC_STEP.
- pop: ins_valid_out & ins_ready_in & !redirect_in. The head is removed at rd_ptr.
- occ_n = count + push − pop. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Next state when no redirect:
  - REQ without completion stays REQ.
  - Otherwise the FSM enters REQ at fetch_pc if !halt_in & occ_n < DEPTH; else IDLE.
  - IDLE behaves the same way.
- Redirect (priority over everything else):
  - count, rd_ptr and wr_ptr clear; fetch_pc ← redirect_addr_in; no pop.
  - If in REQ or DROP without completion this cycle: enter DROP, keeping the old address and mem_read_out high.
  - Otherwise (including completion this cycle, whose data is discarded): enter REQ at redirect_addr_in if !halt_in, else IDLE.
- DROP on completion: data is discarded. The FSM goes to REQ at fetch_pc if !halt_in, else IDLE. A second redirect while in DROP only updates fetch_pc.
- halt_in never aborts an outstanding request. A halted fetch completes and is pushed normally.
- Empty queue: ins_valid_out=0, ins_data_out=32'h00000013 (NOP), ins_pc_out=0.
- At most one outstanding request. A request is never launched into a full queue, so overflow is impossible.

## Timing
- Reset values: FSM IDLE, fetch_pc=RESET_ADDR, mem_read_out=0, mem_addr_out=RESET_ADDR, count=0, ins_valid_out=0, ins_data_out=32'h00000013, ins_pc_out=0, queue_count_out=0.
- First cycle after reset release with halt_in=0: FSM in IDLE. The edge ending it launches the request, so mem_read_out=1 with address RESET_ADDR in the second cycle.
- Fetch-to-decode latency: completion in cycle N gives ins_valid_out=1 in N+1.
- Throughput: with mem_valid_in tied high and ins_ready_in=1, one instruction per cycle, and mem_addr_out increments by PC_STEP every cycle.
- Redirect in cycle N:
  - ins_valid_out=0 in N+1.
  - If no fetch is outstanding, mem_addr_out=redirect_addr_in in N+1.
  - First redirected instruction is valid no earlier than N+2.
- Reset mid-operation: the next edge restores all reset values. Any outstanding request is abandoned, and the memory must tolerate this.

## Test plan
- Reset, then halt_in=0, mem_valid_in=1, ins_ready_in=1: ins_pc_out sequence 0x0, 0x4, 0x8, … one per cycle from the third cycle after reset release, with ins_data_out matching the memory model.
- ins_ready_in=0 with DEPTH=4: queue_count_out reaches 4 and mem_read_out drops to 0. Raising ins_ready_in drains PCs in order; fetch resumes the cycle after count falls below 4. Check pointer wrap after 3 fills.
- mem_valid_in delayed 3 cycles per request: mem_addr_out and mem_read_out are stable during each wait, and no duplicate or missing PCs appear.
- redirect_in with redirect_addr_in=0x100 while a request to 0x20 is pending (mem_valid_in=0 for 2 more cycles): FSM enters DROP, and the 0x20 data is discarded. Next request is to 0x100, and the first valid ins_pc_out is 0x100.
- redirect_in in the same cycle as a completion and a pop with count=2: queue empties, nothing from the old stream is delivered, and fetch restarts at redirect_addr_in.
- halt_in asserted while in REQ: the pending fetch is pushed, then mem_read_out=0 with no new requests. Deasserting halt_in resumes at the next sequential PC.
